gemm_tile_controller: RTL and testbench
=======================================

# gemm_tile_controller

Sequencing controller for the GeMM accelerator's 4×16 MAC array. It takes a start pulse and the matrix sizes M, K and N, and walks the output in 4-row × 16-column tiles. For each tile it issues K read addresses to SRAM A (32-bit words, 4 elements each) and SRAM B (128-bit words, 16 elements each), drives valid/clear control to the MAC array, and writes one 2048-bit C word per tile. It sits between the top-level start/size interface and the SRAMs and MAC array inside `gemm_accelerator_top`.

## Interface
Parameters:
- `AddrWidth`, 12: SRAM address width (SRAM depth 4096).
- `SizeAddrWidth`, 32: width of the M/K/N size inputs.
- `RowPar`, 4: tile rows (M direction).
- `ColPar`, 16: tile columns (N direction).

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: start request; sampled only in IDLE.
- `M_size_i`, `K_size_i`, `N_size_i`, in, SizeAddrWidth each: matrix sizes; latched on an accepted start.
- `sram_a_addr_o`, out, AddrWidth: A read address, `mt*K + k`.
- `sram_b_addr_o`, out, AddrWidth: B read address, `nt*K + k`.
- `sram_c_addr_o`, out, AddrWidth: C write address, `mt*NT + nt`.
- `sram_c_we_o`, out, 1: C write strobe.
- `mac_valid_o`, out, 1: SRAM read data valid this cycle; the MAC array accumulates.
- `mac_clear_o`, out, 1: first valid beat of a tile; the MAC array loads the product instead of accumulating.
- `busy_o`, out, 1: high in every state except IDLE.
- `done_o`, out, 1: one-cycle completion pulse.

## Operation
- Derived counts, computed at start:
  - `MT = ceil(M/RowPar)`.
  - `NT = ceil(N/ColPar)`.
  - Partial tiles are processed in full. Zero-padding of A and B is the loader's responsibility.
- States are IDLE, COMPUTE, DRAIN, WRITE and DONE.
- IDLE:
  - `start_i=1` latches the sizes and clears k, mt, nt and all address bases.
  - If any size is 0, go to DONE with no SRAM or MAC activity.
  - Otherwise go to COMPUTE.
- COMPUTE: each cycle drives the A/B addresses for the current k, then increments k. At `k==K-1`, go to DRAIN.
- DRAIN: one cycle that lets the last read return. No address is issued.
- WRITE:
  - `sram_c_we_o=1` at `sram_c_addr_o`.
  - Advance nt (the inner loop) and then mt (the outer loop).
  - If tiles remain, go to COMPUTE with k=0. Otherwise go to DONE.
- DONE: `done_o=1` for one cycle, then go to IDLE.
- Address arithmetic uses running base registers; no multipliers:
  - `a_base += K` on each mt advance.
  - `b_base += K` on each nt advance; `b_base` returns to 0 when mt advances.
  - The C address counter increments on every write.
  - All address arithmetic wraps modulo `2^AddrWidth`.
- `mac_valid_o` is the COMPUTE-issue flag delayed by one register, matching the 1-cycle SRAM read latency.
- `mac_clear_o` equals `mac_valid_o && (k_delayed==0)`.
- `start_i` while busy is ignored; the latched sizes do not change mid-run.

## Timing
- Reset (synchronous, `rst_i`):
  - Next state is IDLE.
  - Every output is 0: all addresses, `sram_c_we_o`, `mac_valid_o`, `mac_clear_o`, `busy_o`, `done_o`.
  - The delay register is cleared.
  - Reset mid-run aborts with no further writes; no `done_o` is produced for that run.
- Start is sampled at edge 0. COMPUTE then occupies cycles 1..K.
- `mac_valid_o` is high in cycles 2..K+1; cycle K+1 is DRAIN.
- WRITE is in cycle K+2 and depends on the MAC array:
  - The MAC array must present its result combinationally by the cycle after its last valid beat.
  - This makes the tile result available exactly in the WRITE cycle.
- The per-tile period is K+2 cycles; the next tile's COMPUTE immediately follows WRITE.
- Total latency from start to `done_o`: `MT*NT*(K+2) + 1` cycles.
- Zero-size run: `done_o` is high in cycle 1.
- `done_o` and `start_i` never overlap. A start in the cycle after `done_o` (IDLE) is accepted.

## Structure
- Package `gemm_ctrl_pkg` holds:
  - the `ctrl_state_e` enum (IDLE, COMPUTE, DRAIN, WRITE, DONE);
  - the `RowPar` and `ColPar` constants;
  - a `ceil_div` function.
- One natural sub-module, `gemm_addr_gen`: owns k/mt/nt counters, base registers and wrap logic; FSM in the controller top drives its `clear`/`step_k`/`step_tile` inputs.

## Test plan
- M=4, K=64, N=16, start pulse:
  - 64 A/B addresses, 0..63;
  - one C write at address 0 in cycle 66;
  - `done_o` in cycle 67;
  - `mac_clear_o` only in cycle 2.
- M=8, K=3, N=32, giving 4 tiles:
  - A address sequence 0,1,2 ×2, then 3,4,5 ×2;
  - B sequence 0,1,2, 3,4,5, 0,1,2, 3,4,5;
  - C writes at 0,1,2,3;
  - `done_o` at cycle 21.
- M=5, K=1, N=17:
  - MT=2, NT=2, so 4 tiles of 3 cycles;
  - `mac_valid_o` and `mac_clear_o` high together on every beat;
  - `done_o` at cycle 13.
- K=0, any M/N:
  - `done_o` at cycle 1;
  - `sram_c_we_o` and `mac_valid_o` never asserted.
- `start_i` held high throughout a run of M=4, K=4, N=16:
  - Run 1 writes C at 0 and pulses `done_o` at cycle 7.
  - Cycle 8 (IDLE) accepts the next start, so a second identical run pulses `done_o` again at cycle 15.
  - No other starts are taken mid-run.
- `rst_i` asserted in cycle 10 of an M=4, K=64, N=16 run:
  - The next cycle is IDLE with all outputs 0.
  - No C write and no `done_o`.
  - A subsequent start runs cleanly.

Source files
------------

// File: rtl/gemm_ctrl_pkg.sv
// gemm_ctrl_pkg: controller state encoding, MAC array tile geometry and tile-count helper.
package gemm_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, COMPUTE, DRAIN, WRITE, DONE} ctrl_state_e;
   localparam int unsigned RowPar = 4;
   localparam int unsigned ColPar = 16;
   function automatic logic [31:0] ceil_div(input logic [31:0] a, input logic [31:0] b);
      return a / b + 32'(a % b != 0);
   endfunction
endpackage

// File: rtl/gemm_addr_gen.sv
// gemm_addr_gen: k/mt/nt loop counters and running SRAM address bases for the tile walk.
module gemm_addr_gen #(
   parameter int unsigned AddrWidth = 12,
   parameter int unsigned SizeAddrWidth = 32,
   parameter int unsigned RowPar = 4,
   parameter int unsigned ColPar = 16
) (
   input logic clk,
   input logic rst,
   input logic clear,
   input logic step_k,
   input logic step_tile,
   input logic [SizeAddrWidth-1:0] m_size,
   input logic [SizeAddrWidth-1:0] k_size,
   input logic [SizeAddrWidth-1:0] n_size,
   output logic [AddrWidth-1:0] a_addr,
   output logic [AddrWidth-1:0] b_addr,
   output logic [AddrWidth-1:0] c_addr,
   output logic k_first,
   output logic k_last,
   output logic tile_last
);
   import gemm_ctrl_pkg::*;
   localparam logic [SizeAddrWidth-1:0] SOne = 1;
   localparam logic [AddrWidth-1:0] AOne = 1;
   logic [SizeAddrWidth-1:0] k_len, k, mt, nt, mt_last, nt_last;
   logic [AddrWidth-1:0] a_base, b_base, c_cnt, k_step;
   logic nt_wrap;
   assign k_step = k_len[AddrWidth-1:0];
   assign nt_wrap = nt == nt_last;
   assign k_first = k == '0;
   assign k_last = k == k_len - SOne;
   assign tile_last = nt_wrap && mt == mt_last;
   assign a_addr = a_base + k[AddrWidth-1:0];
   assign b_addr = b_base + k[AddrWidth-1:0];
   assign c_addr = c_cnt;
   // sizes are latched once per run so later changes on the size inputs are ignored
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         k_len <= rst ? '0 : k_size;
         mt_last <= rst ? '0 : SizeAddrWidth'(ceil_div(32'(m_size), RowPar) - 32'd1);
         nt_last <= rst ? '0 : SizeAddrWidth'(ceil_div(32'(n_size), ColPar) - 32'd1);
         k <= '0;
         mt <= '0;
         nt <= '0;
         a_base <= '0;
         b_base <= '0;
         c_cnt <= '0;
      end else begin
         if (step_k) k <= k_last ? '0 : k + SOne;
         if (step_tile) begin
            nt <= nt_wrap ? '0 : nt + SOne;
            mt <= nt_wrap ? mt + SOne : mt;
            a_base <= nt_wrap ? a_base + k_step : a_base;
            b_base <= nt_wrap ? '0 : b_base + k_step;
            c_cnt <= c_cnt + AOne;
         end
      end
   end
endmodule

// File: rtl/gemm_tile_controller.sv
// gemm_tile_controller: walks an MxKxN GeMM in RowPar x ColPar output tiles,
// issuing SRAM A/B reads, MAC valid/clear and one C write per tile.
module gemm_tile_controller #(
   parameter int unsigned AddrWidth = 12,
   parameter int unsigned SizeAddrWidth = 32,
   parameter int unsigned RowPar = 4,
   parameter int unsigned ColPar = 16
) (
   input logic clk_i,
   input logic rst_i,
   input logic start_i,
   input logic [SizeAddrWidth-1:0] M_size_i,
   input logic [SizeAddrWidth-1:0] K_size_i,
   input logic [SizeAddrWidth-1:0] N_size_i,
   output logic [AddrWidth-1:0] sram_a_addr_o,
   output logic [AddrWidth-1:0] sram_b_addr_o,
   output logic [AddrWidth-1:0] sram_c_addr_o,
   output logic sram_c_we_o,
   output logic mac_valid_o,
   output logic mac_clear_o,
   output logic busy_o,
   output logic done_o
);
   import gemm_ctrl_pkg::*;
   ctrl_state_e state, next;
   logic clear, step_k, step_tile, k_first, k_last, tile_last, issue, zero_size, valid_q, clear_q;
   logic [AddrWidth-1:0] a_addr, b_addr, c_addr;
   assign issue = state == COMPUTE;
   assign zero_size = M_size_i == '0 || K_size_i == '0 || N_size_i == '0;
   gemm_addr_gen #(
      .AddrWidth(AddrWidth),
      .SizeAddrWidth(SizeAddrWidth),
      .RowPar(RowPar),
      .ColPar(ColPar)
   ) u_addr_gen (
      .clk(clk_i),
      .rst(rst_i),
      .clear(clear),
      .step_k(step_k),
      .step_tile(step_tile),
      .m_size(M_size_i),
      .k_size(K_size_i),
      .n_size(N_size_i),
      .a_addr(a_addr),
      .b_addr(b_addr),
      .c_addr(c_addr),
      .k_first(k_first),
      .k_last(k_last),
      .tile_last(tile_last)
   );
   // valid/clear trail the issue cycle by the one-cycle SRAM read latency
   always_ff @(posedge clk_i) begin
      state <= rst_i ? IDLE : next;
      valid_q <= !rst_i && issue;
      clear_q <= !rst_i && issue && k_first;
   end
   always_comb begin
      next = state;
      clear = 1'b0;
      step_k = 1'b0;
      step_tile = 1'b0;
      case (state)
         IDLE: begin
            clear = start_i;
            next = !start_i ? IDLE : zero_size ? DONE : COMPUTE;
         end
         COMPUTE: begin
            step_k = 1'b1;
            next = k_last ? DRAIN : COMPUTE;
         end
         DRAIN: next = WRITE;
         WRITE: begin
            step_tile = 1'b1;
            next = tile_last ? DONE : COMPUTE;
         end
         DONE: next = IDLE;
         default: next = IDLE;
      endcase
   end
   assign sram_a_addr_o = issue ? a_addr : '0;
   assign sram_b_addr_o = issue ? b_addr : '0;
   assign sram_c_we_o = state == WRITE;
   assign sram_c_addr_o = sram_c_we_o ? c_addr : '0;
   assign mac_valid_o = valid_q;
   assign mac_clear_o = clear_q;
   assign busy_o = state != IDLE;
   assign done_o = state == DONE;
endmodule

// File: tb/tb_gemm_tile_controller.sv
// tb_gemm_tile_controller: drives directed and random GeMM runs and compares every cycle
// against a per-cycle expectation table built from the tile-walk timing rules.
module tb_gemm_tile_controller;
   localparam int MAXC = 9000;
   logic clk = 1'b0;
   logic rst_i, start_i;
   logic [31:0] M_size_i, K_size_i, N_size_i;
   logic [11:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
   logic sram_c_we_o, mac_valid_o, mac_clear_o, busy_o, done_o;
   int n_checks = 0;
   int n_errors = 0;
   bit e_busy[MAXC], e_done[MAXC], e_issue[MAXC], e_valid[MAXC], e_clear[MAXC], e_we[MAXC];
   int e_a[MAXC], e_b[MAXC], e_c[MAXC];

   gemm_tile_controller dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .start_i(start_i),
      .M_size_i(M_size_i),
      .K_size_i(K_size_i),
      .N_size_i(N_size_i),
      .sram_a_addr_o(sram_a_addr_o),
      .sram_b_addr_o(sram_b_addr_o),
      .sram_c_addr_o(sram_c_addr_o),
      .sram_c_we_o(sram_c_we_o),
      .mac_valid_o(mac_valid_o),
      .mac_clear_o(mac_clear_o),
      .busy_o(busy_o),
      .done_o(done_o)
   );

   always #5 clk = ~clk;

   task automatic clear_model();
      for (int i = 0; i < MAXC; i++) begin
         e_busy[i] = 0; e_done[i] = 0; e_issue[i] = 0; e_valid[i] = 0; e_clear[i] = 0; e_we[i] = 0;
         e_a[i] = 0; e_b[i] = 0; e_c[i] = 0;
      end
   endtask

   // one run whose start is sampled at the edge ending cycle off; len = cycles until done
   task automatic model_run(input int off, input int mm, input int kk, input int nn, output int len);
      int mtn, ntn, s;
      if (mm == 0 || kk == 0 || nn == 0) begin
         e_busy[off+1] = 1;
         e_done[off+1] = 1;
         len = 1;
         return;
      end
      mtn = (mm + 3) / 4;
      ntn = (nn + 15) / 16;
      for (int mt = 0; mt < mtn; mt++)
         for (int nt = 0; nt < ntn; nt++) begin
            s = off + (mt * ntn + nt) * (kk + 2);
            for (int c = 1; c <= kk + 2; c++) e_busy[s+c] = 1;
            for (int k = 0; k < kk; k++) begin
               e_issue[s+1+k] = 1;
               e_a[s+1+k] = (mt * kk + k) % 4096;
               e_b[s+1+k] = (nt * kk + k) % 4096;
               e_valid[s+2+k] = 1;
            end
            e_clear[s+2] = 1;
            e_we[s+kk+2] = 1;
            e_c[s+kk+2] = (mt * ntn + nt) % 4096;
         end
      len = mtn * ntn * (kk + 2) + 1;
      e_busy[off+len] = 1;
      e_done[off+len] = 1;
   endtask

   task automatic test_run(input string name, input int mm, input int kk, input int nn, input bit hold);
      int len1, len2, total, done_at, n_done, want_done;
      logic [4:0] got_ctl, exp_ctl;
      clear_model();
      model_run(0, mm, kk, nn, len1);
      total = len1;
      want_done = 1;
      if (hold) begin
         model_run(len1 + 1, mm, kk, nn, len2);
         total = len1 + 1 + len2;
         want_done = 2;
      end
      M_size_i = mm; K_size_i = kk; N_size_i = nn;
      start_i = 1'b1;
      done_at = -1;
      n_done = 0;
      for (int c = 1; c <= total + 1; c++) begin
         @(posedge clk); #1;
         if (c == 1 && !hold) begin
            start_i = 1'b0;
            M_size_i = $urandom; K_size_i = $urandom; N_size_i = $urandom;
         end
         if (hold && c == total) start_i = 1'b0;
         got_ctl = {busy_o, done_o, sram_c_we_o, mac_valid_o, mac_clear_o};
         exp_ctl = {e_busy[c], e_done[c], e_we[c], e_valid[c], e_clear[c]};
         n_checks++;
         if (got_ctl !== exp_ctl) begin
            n_errors++;
            $display("FAIL %s ctl cycle %0d: busy/done/we/valid/clear got %b want %b", name, c, got_ctl, exp_ctl);
         end
         if (e_issue[c]) begin
            n_checks++;
            if (sram_a_addr_o !== 12'(e_a[c]) || sram_b_addr_o !== 12'(e_b[c])) begin
               n_errors++;
               $display("FAIL %s ab_addr cycle %0d: got a=%0d b=%0d want a=%0d b=%0d", name, c, sram_a_addr_o, sram_b_addr_o, e_a[c], e_b[c]);
            end
         end
         if (e_we[c]) begin
            n_checks++;
            if (sram_c_addr_o !== 12'(e_c[c])) begin
               n_errors++;
               $display("FAIL %s c_addr cycle %0d: got %0d want %0d", name, c, sram_c_addr_o, e_c[c]);
            end
         end
         if (done_o === 1'b1) begin
            n_done++;
            if (done_at < 0) done_at = c;
         end
      end
      n_checks++;
      if (done_at != len1 || n_done != want_done) begin
         n_errors++;
         $display("FAIL %s done_timing: got first=%0d count=%0d want first=%0d count=%0d", name, done_at, n_done, len1, want_done);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; M_size_i = 4; K_size_i = 4; N_size_i = 16;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (i == 1) start_i = 1'b1;
         n_checks++;
         if ({sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o, mac_valid_o, mac_clear_o, busy_o, done_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b we=%b valid=%b want all 0", busy_o, done_o, sram_c_we_o, mac_valid_o);
         end
      end
      start_i = 1'b0;
      rst_i = 1'b0;
   endtask

   task automatic test_reset_midrun();
      int bad;
      M_size_i = 4; K_size_i = 64; N_size_i = 16;
      start_i = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
      end
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      n_checks++;
      if ({sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o, mac_valid_o, mac_clear_o, busy_o, done_o} !== '0) begin
         n_errors++;
         $display("FAIL midrun_reset_outputs: got busy=%b valid=%b a=%0d want all 0", busy_o, mac_valid_o, sram_a_addr_o);
      end
      bad = 0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk); #1;
         if (sram_c_we_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL midrun_reset_quiet: got %0d active cycles want 0", bad);
      end
      test_run("after_reset", 4, 64, 16, 1'b0);
   endtask

   task automatic test_directed();
      test_run("single_tile_k64", 4, 64, 16, 1'b0);
      test_run("four_tiles_k3", 8, 3, 32, 1'b0);
      test_run("partial_k1", 5, 1, 17, 1'b0);
      test_run("addr_wrap", 8, 2100, 16, 1'b0);
   endtask

   task automatic test_zero_size();
      test_run("zero_k", 9, 0, 40, 1'b0);
      test_run("zero_m", 0, 5, 16, 1'b0);
      test_run("zero_n", 3, 7, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      test_run("start_held", 4, 4, 16, 1'b1);
      test_run("start_held_multi", 7, 2, 20, 1'b1);
   endtask

   task automatic test_random();
      int mm, kk, nn;
      for (int i = 0; i < 14; i++) begin
         mm = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
         kk = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 10);
         nn = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 70);
         test_run("random", mm, kk, nn, 1'($urandom_range(0, 3) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_zero_size();
      test_back_to_back();
      test_reset_midrun();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
